// File: rtl/fifo.sv
// Byte-wide first-word-fall-through FIFO.
// The head byte is visible on data_out whenever the FIFO is not empty.
module fifo #(
  parameter int num_slots = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full
);
  localparam int PW = (num_slots > 1) ? $clog2(num_slots) : 1;
  localparam int CW = $clog2(num_slots + 1);
  localparam logic [PW-1:0] LAST = PW'(num_slots - 1);
  localparam logic [CW-1:0] SLOTS = CW'(num_slots);

  logic [7:0]    mem_q [num_slots];
  logic [7:0]    mem_d [num_slots];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_rd, do_wr;

  always_comb begin
    empty = (cnt_q == '0);
    full  = (cnt_q == SLOTS);
    do_rd = rd && !empty;
    // a full FIFO still accepts a write when the head leaves this cycle
    do_wr = wr && (!full || do_rd);
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_wr) begin
      mem_d[wp_q] = data_in;
      wp_d = (wp_q == LAST) ? '0 : wp_q + PW'(1);
    end
    if (do_rd) begin
      rp_d = (rp_q == LAST) ? '0 : rp_q + PW'(1);
    end
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign data_out = mem_q[rp_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: 8'h00};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rs232_rxb.sv
// Buffered 8N1 RS232 receiver: mid-bit sampling, stop-bit check,
// FWFT byte FIFO and sticky framing/overrun flags.
module rs232_rxb #(
  parameter int clock_freq = 50000000,
  parameter int num_slots  = 63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fsel,
  input  logic       rxd,
  input  logic       rd,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);
  localparam int BAUD_SLOW = 19200;
  localparam int BAUD_FAST = 115200;
  localparam int LIM_S = clock_freq / BAUD_SLOW;
  localparam int LIM_F = clock_freq / BAUD_FAST;
  localparam int CW = $clog2(clock_freq / BAUD_SLOW + 1);
  localparam logic [CW-1:0] LIM_S_M1 = CW'(LIM_S - 1);
  localparam logic [CW-1:0] LIM_F_M1 = CW'(LIM_F - 1);
  localparam logic [CW-1:0] HALF_S_M1 = CW'(LIM_S / 2 - 1);
  localparam logic [CW-1:0] HALF_F_M1 = CW'(LIM_F / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          prev_q, prev_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          fast_q, fast_d;
  logic          frm_q, frm_d;
  logic          ovr_q, ovr_d;
  logic          fifo_wr, frm_set, ovr_set;
  logic          expired, rx;
  logic [CW-1:0] lim_m1;

  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rx      = sync2_q;
    expired = (cnt_q == '0);
    lim_m1  = fast_q ? LIM_F_M1 : LIM_S_M1;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    fast_d  = fast_q;
    fifo_wr = 1'b0;
    frm_set = 1'b0;
    ovr_set = 1'b0;
    if (state_q != S_IDLE && !expired) begin
      cnt_d = cnt_q - CW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (prev_q && !rx) begin
          state_d = S_START;
          fast_d  = fsel;
          cnt_d   = fsel ? HALF_F_M1 : HALF_S_M1;
        end
      end
      S_START: begin
        if (expired) begin
          if (rx) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = lim_m1;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (expired) begin
          shift_d[idx_q] = rx;
          cnt_d = lim_m1;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (expired) begin
          state_d = S_IDLE;
          if (!rx)              frm_set = 1'b1;
          else if (!full || rd) fifo_wr = 1'b1;
          else                  ovr_set = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a new error event outranks a same-cycle clear
    frm_d = frm_set | (frm_q & ~err_clr);
    ovr_d = ovr_set | (ovr_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      fast_q  <= 1'b0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      fast_q  <= fast_d;
      frm_q   <= frm_d;
      ovr_q   <= ovr_d;
    end
  end

  assign frame_err = frm_q;
  assign overrun   = ovr_q;

  fifo #(
    .num_slots(num_slots)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (fifo_wr),
    .rd      (rd),
    .data_in (shift_q),
    .data_out(data_out),
    .empty   (empty),
    .full    (full)
  );
endmodule

// File: tb/tb_rs232_rxb.sv
// Bench for rs232_rxb: serial frames built from bit times,
// expected bytes kept in a queue model of the FIFO.
module tb_rs232_rxb;
  localparam int CLK_HZ = 4_000_000;
  localparam int SLOTS = 4;
  localparam int LS = CLK_HZ / 19200;
  localparam int LF = CLK_HZ / 115200;
  localparam int HS = LS / 2;
  localparam int HF = LF / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fsel = 1'b0;
  logic       rxd = 1'b1;
  logic       rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       empty, full, frame_err, overrun;

  int checks = 0;
  int failures = 0;
  logic [7:0] expq[$];

  always #5 clk = ~clk;

  rs232_rxb #(
    .clock_freq(CLK_HZ),
    .num_slots (SLOTS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fsel     (fsel),
    .rxd      (rxd),
    .rd       (rd),
    .err_clr  (err_clr),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic flip);
    int l;
    l = fsel ? LF : LS;
    rxd = 1'b0;
    idle(l);
    if (flip) fsel = ~fsel;
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      idle(l);
    end
    rxd = stop_b;
    idle(l);
    rxd = 1'b1;
  endtask

  task automatic read_fifo(output logic [7:0] b, output logic e);
    e = empty;
    b = data_out;
    rd = 1'b1;
    idle(1);
    rd = 1'b0;
  endtask

  task automatic test_reset;
    bit seen;
    rst_n = 1'b0;
    rxd = 1'b1;
    fsel = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL reset_empty got=%b exp=1", empty);
    end
    checks++;
    if (full !== 1'b0) begin
      failures++; $display("FAIL reset_full got=%b exp=0", full);
    end
    checks++;
    if (data_out !== 8'h00) begin
      failures++; $display("FAIL reset_data got=%h exp=00", data_out);
    end
    checks++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b exp=00", frame_err, overrun);
    end
    seen = 0;
    repeat (20 * LF) begin
      idle(1);
      if (empty !== 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL reset_no_write got=write exp=none");
    end
  endtask

  task automatic test_fast_latency;
    int n;
    bit got;
    logic [7:0] b;
    logic e;
    int expn;
    expn = 2 + HF + 9 * LF + 1;
    fsel = 1'b1;
    n = 0;
    got = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (!got && n < 12 * LF) begin
          @(posedge clk);
          #1;
          n++;
          if (empty === 1'b0) got = 1;
        end
      end
    join
    checks++;
    if (!got || n < expn - 2 || n > expn + 2) begin
      failures++;
      $display("FAIL a5_latency got=%0d exp=%0d+-2", n, expn);
    end
    checks++;
    if (data_out !== 8'hA5) begin
      failures++; $display("FAIL a5_data got=%h exp=a5", data_out);
    end
    read_fifo(b, e);
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL a5_pop_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [3];
    logic [7:0] b;
    logic e;
    pat = '{8'h00, 8'hFF, 8'h55};
    fsel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(pat[i], 1'b1, 1'b0);
      expq.push_back(pat[i]);
    end
    idle(2);
    for (int i = 0; i < 3; i++) begin
      read_fifo(b, e);
      checks++;
      if (e !== 1'b0 || b !== expq[0]) begin
        failures++;
        $display("FAIL b2b_byte%0d got=%h/e%b exp=%h", i, b, e, expq[0]);
      end
      void'(expq.pop_front());
    end
    checks++;
    if (empty !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after got=%b%b%b exp=100", empty, frame_err,
               overrun);
    end
  endtask

  task automatic test_glitch;
    logic [7:0] b;
    logic e;
    fsel = 1'b0;
    rxd = 1'b0;
    idle(100);
    rxd = 1'b1;
    idle(2 * LS);
    checks++;
    if (empty !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL glitch got=%b%b%b exp=100", empty, frame_err, overrun);
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2);
    read_fifo(b, e);
    checks++;
    if (e !== 1'b0 || b !== 8'h3C) begin
      failures++; $display("FAIL glitch_next got=%h/e%b exp=3c", b, e);
    end
  endtask

  task automatic test_frame_err;
    fsel = 1'b1;
    send_frame(8'h81, 1'b0, 1'b0);
    idle(LF);
    checks++;
    if (empty !== 1'b1 || frame_err !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL frame_err got=%b%b%b exp=110", empty, frame_err,
               overrun);
    end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL frame_clr got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_random;
    int n;
    logic [7:0] v;
    logic [7:0] b;
    logic e;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, SLOTS);
      for (int j = 0; j < n; j++) begin
        fsel = 1'($urandom);
        v = 8'($urandom);
        send_frame(v, 1'b1, 1'($urandom));
        expq.push_back(v);
        idle($urandom_range(0, 5));
      end
      idle(2);
      while (expq.size() > 0) begin
        read_fifo(b, e);
        checks++;
        if (e !== 1'b0 || b !== expq[0]) begin
          failures++;
          $display("FAIL rand_byte got=%h/e%b exp=%h", b, e, expq[0]);
        end
        void'(expq.pop_front());
      end
      checks++;
      if (empty !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
        failures++;
        $display("FAIL rand_after got=%b%b%b exp=100", empty, frame_err,
                 overrun);
      end
    end
  endtask

  task automatic test_overrun;
    logic [7:0] v;
    logic [7:0] b;
    logic e;
    int k;
    k = 3 + HF + 9 * LF;
    fsel = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < SLOTS; j++) begin
        v = 8'($urandom);
        send_frame(v, 1'b1, 1'b0);
        expq.push_back(v);
      end
      idle(2);
      checks++;
      if (full !== 1'b1) begin
        failures++; $display("FAIL ovr_full%0d got=%b exp=1", pass, full);
      end
      v = 8'($urandom);
      if (pass == 0) begin
        send_frame(v, 1'b1, 1'b0);
      end else begin
        fork
          send_frame(v, 1'b1, 1'b0);
          begin
            idle(k - 1);
            rd = 1'b1;
            idle(1);
            rd = 1'b0;
          end
        join
        void'(expq.pop_front());
        expq.push_back(v);
      end
      idle(2);
      checks++;
      if (overrun !== (pass == 0) || full !== 1'b1) begin
        failures++;
        $display("FAIL ovr_flag%0d got=%b/f%b exp=%0d", pass, overrun,
                 full, pass == 0);
      end
      while (expq.size() > 0) begin
        read_fifo(b, e);
        checks++;
        if (e !== 1'b0 || b !== expq[0]) begin
          failures++;
          $display("FAIL ovr_byte%0d got=%h/e%b exp=%h", pass, b, e,
                   expq[0]);
        end
        void'(expq.pop_front());
      end
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
        failures++; $display("FAIL ovr_clr%0d got=%b exp=0", pass, overrun);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] v;
    logic [7:0] b;
    logic e;
    fsel = 1'b1;
    send_frame(8'($urandom), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (empty !== 1'b0) begin
      failures++; $display("FAIL mid_pre got=%b exp=0", empty);
    end
    rxd = 1'b0;
    idle(LF);
    rxd = 1'b1;
    idle(3 * LF);
    rst_n = 1'b0;
    idle(2);
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL mid_rst_empty got=%b exp=1", empty);
    end
    rxd = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(12 * LF);
    checks++;
    if (empty !== 1'b1 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL mid_after got=%b%b%b exp=100", empty, frame_err,
               overrun);
    end
    v = 8'($urandom);
    send_frame(v, 1'b1, 1'b0);
    idle(2);
    read_fifo(b, e);
    checks++;
    if (e !== 1'b0 || b !== v) begin
      failures++; $display("FAIL mid_next got=%h/e%b exp=%h", b, e, v);
    end
  endtask

  initial begin
    test_reset();
    test_fast_latency();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_random();
    test_overrun();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs232_rxb.md
# rs232_rxb

Buffered RS232 receiver: the receive-side counterpart of the buffered transmitter in the serial I/O path. Samples an asynchronous 8N1 line at mid-bit, assembles bytes LSB first, checks the stop bit and pushes good bytes into a first-word-fall-through FIFO. The bus-side I/O register reads the FIFO. Framing and overrun conditions are flagged sticky until cleared.

## Interface
- `clock_freq`, default 50000000: system clock in Hz; sets the bit-time divisors.
- `num_slots`, default 63: FIFO depth in bytes.

- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `fsel` in 1: baud select; 0 = 19200, 1 = 115200.
- `rxd` in 1: serial line, asynchronous, idle high.
- `rd` in 1: pop the FIFO head; ignored when `empty`.
- `err_clr` in 1: one-cycle pulse clears `frame_err` and `overrun`.
- `data_out` out 8: FIFO head byte, valid while `empty`=0.
- `empty` out 1: FIFO holds no byte.
- `full` out 1: FIFO holds `num_slots` bytes.
- `frame_err` out 1: sticky; a frame had stop bit 0.
- `overrun` out 1: sticky; a good byte was dropped because the FIFO was full.

## Operation
- `rxd` passes through a 2-flop synchroniser. Both flops reset to 1, so reset never produces a spurious start.
- Divisors use truncating integer division: `limit` = clock_freq/baud and `half` = limit/2. At 50 MHz: 2604/1302 at 19200 and 434/217 at 115200.
- Counter width is $clog2(clock_freq/19200 + 1).
- `fsel` is latched at start detection. Changing it mid-frame has no effect until the next frame.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised high-to-low transition loads `half`-1 and moves to START.
  - START: when the counter expires, sample the line. If the line is 1, treat it as a glitch and return to IDLE with no flag. If 0, load `limit`-1, clear the bit index and go to DATA.
  - DATA: when the counter expires, shift the sample into bit[index], reload `limit`-1 and increment the index. After the sample with index 7, go to STOP.
  - STOP: when the counter expires, sample the line.
    - Sample 1 and FIFO not full, or FIFO full with `rd` in the same cycle: write the byte.
    - Sample 1, FIFO full, no `rd`: drop the byte and set `overrun`.
    - Sample 0: drop the byte and set `frame_err`.
    - In every case return to IDLE in the same cycle. This allows back-to-back frames with one stop bit.
- FIFO behaviour:
  - Simultaneous read and write are allowed at any fill level.
  - `rd` when `empty` is ignored; `data_out` holds and no pointer moves.
- Error flags:
  - If `err_clr` and a new error event occur in the same cycle, set wins.
  - Flags have no effect on reception.

## Timing
- Reset values: `empty`=1, `full`=0, `data_out`=8'h00, `frame_err`=0, `overrun`=0. FSM in IDLE, counter and shift register 0.
- Reset mid-frame aborts the frame and empties the FIFO. Reception resumes at the next falling edge after release.
- Latency: the FIFO write edge occurs 2 + `half` + 9·`limit` cycles (±1) after the `rxd` falling edge. `empty` falls on the following cycle. Benches allow ±2 cycles.
- `data_out` is combinational from the FIFO head. After an `rd` edge the next byte is presented in the following cycle.
- The error flags update on the clock edge of the STOP sample.

## Structure
- No shared package. Baud constants (19200, 115200) and the state encoding are localparams in the module.
- One sub-module instance: the existing `fifo` (parameter `num_slots`, ports wr/rd/data_in/data_out/empty/full).
- The receive FSM, synchroniser and divider are inline (≈150–250 lines).
- The `fifo` instance must be asynchronous-reset-compatible: it is driven by the same `rst_n`.

## Test plan
- Reset with `rxd`=1 → `empty`=1, `full`=0, `data_out`=00, both flags 0. No write occurs within 20 bit-times.
- `fsel`=1, 50 MHz, send 8'hA5 (8N1) → within 2+217+9·434 ±2 cycles, `empty`=0 and `data_out`=A5. `rd` pulse → `empty`=1.
- `fsel`=0, send 00, FF, 55 back-to-back with one stop bit → three bytes read in order, flags 0.
- A 100-cycle low glitch on `rxd` at 19200 → no write, no flag, FSM back in IDLE. A following 8'h3C is received correctly.
- Send 8'h81 with stop bit forced 0 → no write, `frame_err`=1. `err_clr` → 0.
- Fill with `num_slots` bytes → `full`=1. The next byte → dropped and `overrun`=1. Repeat with `rd` asserted on the write cycle → byte accepted, no overrun. Reset mid-frame → FIFO empty, no partial byte.
